gf12_sram_sp_8192x64_hd: RTL and testbench



---
 rtl/gf12_sram_sp_8192x64_hd.sv | 73 +++++++
 tb/tb_gf12_sram_sp_8192x64_hd.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gf12_sram_sp_8192x64_hd.sv
// Behavioural 8192x64 single-port synchronous SRAM with per-bit write mask.
// Define SRAM_ASSERT_EN to add simulation-only X/Z checks on access controls.
module gf12_sram_sp_8192x64_hd #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 64
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              CE0,
   input  logic [ADDR_W-1:0] A0,
   input  logic [DATA_W-1:0] D0,
   input  logic              WE0,
   input  logic [DATA_W-1:0] WEM0,
   output logic [DATA_W-1:0] Q0
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] q_q;
   logic [DATA_W-1:0] q_d;
   logic [DATA_W-1:0] wr_d;
   logic [DATA_W-1:0] rd_word;
   logic              rd_en;
   logic              wr_en;

   assign rd_word = mem_q[A0];

`ifdef SRAM_ASSERT_EN
   logic ctl_bad;

   assign ctl_bad = CE0 & ($isunknown(A0) | $isunknown(WE0) |
                           ((WE0 !== 1'b0) & $isunknown(WEM0)));

   // A bad access poisons whatever it may have touched before stopping.
   assign rd_en = ctl_bad ? (WE0 !== 1'b1) : (CE0 & ~WE0);
   assign wr_en = ctl_bad ? (WE0 !== 1'b0) : (CE0 & WE0);
   assign wr_d  = ctl_bad ? {DATA_W{1'bx}} :
                  ((rd_word & ~WEM0) | (D0 & WEM0));
   assign q_d   = ctl_bad ? {DATA_W{1'bx}} :
                  (rd_en ? rd_word : q_q);

   always @(posedge CLK) begin
      if (RSTN && ctl_bad) begin
         $display("ERROR: %m: X/Z on A0/WE0/WEM0 during access");
         $finish;
      end
   end
`else
   assign rd_en = CE0 & ~WE0;
   assign wr_en = CE0 & WE0;
   assign wr_d  = (rd_word & ~WEM0) | (D0 & WEM0);
   assign q_d   = rd_en ? rd_word : q_q;
`endif

   // Array has no reset; RSTN only blocks writes.
   always_ff @(posedge CLK) begin
      if (RSTN && wr_en) begin
         mem_q[A0] <= wr_d;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign Q0 = q_q;

endmodule

// File: tb/tb_gf12_sram_sp_8192x64_hd.sv
// Directed self-checking bench for gf12_sram_sp_8192x64_hd.
module tb_gf12_sram_sp_8192x64_hd;

   logic        CLK;
   logic        RSTN;
   logic        CE0;
   logic [12:0] A0;
   logic [63:0] D0;
   logic        WE0;
   logic [63:0] WEM0;
   logic [63:0] Q0;

   int checks;
   int failures;

   gf12_sram_sp_8192x64_hd dut (
      .CLK  (CLK),
      .RSTN (RSTN),
      .CE0  (CE0),
      .A0   (A0),
      .D0   (D0),
      .WE0  (WE0),
      .WEM0 (WEM0),
      .Q0   (Q0)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic do_write(input logic [12:0] a, input logic [63:0] d,
                           input logic [63:0] m);
      @(negedge CLK);
      CE0  = 1'b1;
      WE0  = 1'b1;
      A0   = a;
      D0   = d;
      WEM0 = m;
      @(negedge CLK);
      CE0  = 1'b0;
      WE0  = 1'b0;
   endtask

   task automatic do_read(input logic [12:0] a);
      @(negedge CLK);
      CE0 = 1'b1;
      WE0 = 1'b0;
      A0  = a;
      @(negedge CLK);
      CE0 = 1'b0;
   endtask

   task automatic test_reset();
      RSTN = 1'b0;
      CE0  = 1'b0;
      WE0  = 1'b0;
      A0   = '0;
      D0   = '0;
      WEM0 = '0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checks++;
      if (Q0 !== 64'h0) begin
         failures++;
         $display("FAIL reset_q0 got=%h exp=%h", Q0, 64'h0);
      end
      RSTN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         checks++;
         if (Q0 !== 64'h0) begin
            failures++;
            $display("FAIL reset_idle%0d got=%h exp=%h", i, Q0, 64'h0);
         end
      end
   endtask

   task automatic test_full_rw();
      do_write(13'h0000, 64'hDEADBEEF_01234567, '1);
      do_read(13'h0000);
      checks++;
      if (Q0 !== 64'hDEADBEEF_01234567) begin
         failures++;
         $display("FAIL full_rw got=%h exp=%h", Q0, 64'hDEADBEEF_01234567);
      end
   endtask

   task automatic test_bitmask();
      do_write(13'h1FFF, 64'hFFFF_FFFF_FFFF_FFFF, '1);
      do_write(13'h1FFF, 64'h0, 64'h0000_0000_FFFF_0000);
      do_read(13'h1FFF);
      checks++;
      if (Q0 !== 64'hFFFF_FFFF_0000_FFFF) begin
         failures++;
         $display("FAIL bitmask got=%h exp=%h", Q0, 64'hFFFF_FFFF_0000_FFFF);
      end
      do_write(13'h1FFF, 64'h0, 64'h0);
      checks++;
      if (Q0 !== 64'hFFFF_FFFF_0000_FFFF) begin
         failures++;
         $display("FAIL zeromask_q got=%h exp=%h", Q0, 64'hFFFF_FFFF_0000_FFFF);
      end
      do_read(13'h1FFF);
      checks++;
      if (Q0 !== 64'hFFFF_FFFF_0000_FFFF) begin
         failures++;
         $display("FAIL zeromask_mem got=%h exp=%h", Q0, 64'hFFFF_FFFF_0000_FFFF);
      end
      do_read(13'h0000);
      checks++;
      if (Q0 !== 64'hDEADBEEF_01234567) begin
         failures++;
         $display("FAIL no_wrap got=%h exp=%h", Q0, 64'hDEADBEEF_01234567);
      end
   endtask

   task automatic test_write_no_disturb();
      do_write(13'd5, 64'h55, '1);
      do_read(13'd5);
      checks++;
      if (Q0 !== 64'h55) begin
         failures++;
         $display("FAIL rd5 got=%h exp=%h", Q0, 64'h55);
      end
      do_write(13'd6, 64'h66, '1);
      checks++;
      if (Q0 !== 64'h55) begin
         failures++;
         $display("FAIL wr_no_disturb got=%h exp=%h", Q0, 64'h55);
      end
      do_read(13'd6);
      checks++;
      if (Q0 !== 64'h66) begin
         failures++;
         $display("FAIL raw6 got=%h exp=%h", Q0, 64'h66);
      end
   endtask

   task automatic test_idle_hold();
      do_write(13'd10, 64'hA5A5_A5A5_A5A5_A5A5, '1);
      do_read(13'd10);
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         CE0  = 1'b0;
         A0   = 13'($urandom);
         D0   = {$urandom, $urandom};
         WE0  = 1'($urandom);
         WEM0 = '1;
         checks++;
         if (Q0 !== 64'hA5A5_A5A5_A5A5_A5A5) begin
            failures++;
            $display("FAIL idle_hold%0d got=%h exp=%h", i, Q0,
                     64'hA5A5_A5A5_A5A5_A5A5);
         end
      end
      WE0 = 1'b0;
      do_read(13'd5);
      checks++;
      if (Q0 !== 64'h55) begin
         failures++;
         $display("FAIL idle_mem5 got=%h exp=%h", Q0, 64'h55);
      end
      do_read(13'd6);
      checks++;
      if (Q0 !== 64'h66) begin
         failures++;
         $display("FAIL idle_mem6 got=%h exp=%h", Q0, 64'h66);
      end
      do_read(13'd10);
      checks++;
      if (Q0 !== 64'hA5A5_A5A5_A5A5_A5A5) begin
         failures++;
         $display("FAIL idle_mem10 got=%h exp=%h", Q0,
                  64'hA5A5_A5A5_A5A5_A5A5);
      end
      do_read(13'h1FFF);
      checks++;
      if (Q0 !== 64'hFFFF_FFFF_0000_FFFF) begin
         failures++;
         $display("FAIL idle_mem1fff got=%h exp=%h", Q0, 64'hFFFF_FFFF_0000_FFFF);
      end
   endtask

   task automatic test_async_reset();
      @(negedge CLK);
      CE0 = 1'b1;
      WE0 = 1'b0;
      A0  = 13'd5;
      @(negedge CLK);
      A0  = 13'd6;
      checks++;
      if (Q0 !== 64'h55) begin
         failures++;
         $display("FAIL b2b_rd5 got=%h exp=%h", Q0, 64'h55);
      end
      @(posedge CLK);
      #3;
      RSTN = 1'b0;
      #1;
      checks++;
      if (Q0 !== 64'h0) begin
         failures++;
         $display("FAIL async_rst got=%h exp=%h", Q0, 64'h0);
      end
      @(negedge CLK);
      CE0  = 1'b1;
      WE0  = 1'b1;
      A0   = 13'd5;
      D0   = 64'hFFFF_0000_FFFF_0000;
      WEM0 = '1;
      @(negedge CLK);
      checks++;
      if (Q0 !== 64'h0) begin
         failures++;
         $display("FAIL rst_hold got=%h exp=%h", Q0, 64'h0);
      end
      CE0  = 1'b0;
      WE0  = 1'b0;
      RSTN = 1'b1;
      do_read(13'd5);
      checks++;
      if (Q0 !== 64'h55) begin
         failures++;
         $display("FAIL rst_nowrite got=%h exp=%h", Q0, 64'h55);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_full_rw();
      test_bitmask();
      test_write_no_disturb();
      test_idle_hold();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
